linreg_coeff_engine: RTL and testbench

Parametrised streaming linear-regression coefficient engine. It accepts up to NMAX signed fixed-point (x, y) samples over a valid/ready handshake, accumulates the running sums, and computes the least-squares intercept B0 and slope B1 with a shared sequential divider. It sits between the sample loader and the error-evaluation stage, and succeeds the fixed-width, fixed-count coefficient calculator. New over that block: width and sample-count generality, runtime sample count, backpressure, degenerate-data and saturation flags.

---
 rtl/linreg_coeff_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_linreg_coeff_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/linreg_coeff_engine.sv
// linreg_coeff_engine: streaming least-squares fit y = b0 + b1*x over up to
// NMAX signed Q(W-FRAC).FRAC samples. Running sums are kept at full precision
// and one restoring sign-magnitude divider is shared by the slope and the
// intercept divides.
//
// state | meaning
// IDLE  | waiting for start, previous results held
// ACC   | accepting samples, updating Sx, Sy, Sxx, Sxy
// PROD  | registering n*Sxy, Sx*Sy, n*Sxx, Sx*Sx
// DIFF  | forming num/den; load slope divide or flag degenerate data
// DIV1  | slope divide (num << FRAC) / den, saturated into b1
// NUM0  | two steps: b1*Sx, then m = Sy - (b1*Sx >>> FRAC), load divide
// DIV0  | intercept divide m / n, saturated into b0
// DONE  | one-cycle done pulse
module linreg_coeff_engine #(
   parameter int W    = 20,
   parameter int FRAC = 10,
   parameter int NMAX = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [$clog2(NMAX+1)-1:0]    n_samples,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [W-1:0]          x,
   input  logic signed [W-1:0]          y,
   output logic                         busy,
   output logic                         done,
   output logic signed [W-1:0]          b0,
   output logic signed [W-1:0]          b1,
   output logic                         degen,
   output logic                         sat
);

   localparam int LOGN = $clog2(NMAX + 1);
   // four sample widths for the product-of-sums terms, two count widths for
   // the n scaling, two guard bits for the difference and its sign
   localparam int IW   = 4*W + 2*$clog2(NMAX) + 2;
   localparam int CW   = $clog2(IW + 1);

   localparam logic [LOGN-1:0]     NMAX_L = LOGN'(NMAX);
   localparam logic signed [IW-1:0] SMAX  = {{(IW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [IW-1:0] SMIN  = {{(IW-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE, ACC, PROD, DIFF, DIV1, NUM0, DIV0, DONE
   } state_t;

   state_t state;

   logic [LOGN-1:0]       n_reg;
   logic [LOGN-1:0]       smp_left;
   logic signed [IW-1:0]  sx, sy, sxx, sxy;
   logic signed [IW-1:0]  p_nsxy, p_sxsy, p_nsxx, p_sxsx;
   logic signed [IW-1:0]  m_prod;
   logic                  num0_ph;

   logic [IW-1:0]         div_rem;
   logic [IW-1:0]         div_q;
   logic [IW-1:0]         div_d;
   logic                  div_neg;
   logic [CW-1:0]         div_cnt;

   logic [LOGN-1:0]       n_clamp;
   logic signed [IW-1:0]  xe, ye, ne, b1e;
   logic signed [IW-1:0]  num_c, den_c, m_c, q_sgn;
   logic [IW:0]           rem_sh;
   logic                  rem_ge;
   logic [IW-1:0]         rem_nxt, q_nxt;
   logic signed [W-1:0]   q_sat;
   logic                  q_clip;

   function automatic logic [IW-1:0] mag(input logic signed [IW-1:0] v);
      mag = v[IW-1] ? -v : v;
   endfunction

   // operand extension, difference terms, one divider step and saturation
   always_comb begin
      n_clamp = (n_samples > NMAX_L) ? NMAX_L : n_samples;
      xe      = IW'(x);
      ye      = IW'(y);
      ne      = IW'(n_reg);
      b1e     = IW'(b1);
      num_c   = p_nsxy - p_sxsy;
      den_c   = p_nsxx - p_sxsx;
      m_c     = sy - (m_prod >>> FRAC);
      rem_sh  = {div_rem, div_q[IW-1]};
      rem_ge  = rem_sh >= {1'b0, div_d};
      rem_nxt = rem_ge ? IW'(rem_sh - {1'b0, div_d}) : rem_sh[IW-1:0];
      q_nxt   = {div_q[IW-2:0], rem_ge};
      q_sgn   = div_neg ? -$signed(q_nxt) : $signed(q_nxt);
      q_sat   = q_sgn[W-1:0];
      q_clip  = 1'b0;
      if (q_sgn > SMAX) begin
         q_sat  = {1'b0, {(W-1){1'b1}}};
         q_clip = 1'b1;
      end else if (q_sgn < SMIN) begin
         q_sat  = {1'b1, {(W-1){1'b0}}};
         q_clip = 1'b1;
      end
   end

   // sequencing FSM with accumulators, shared divider and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         n_reg    <= '0;
         smp_left <= '0;
         sx       <= '0;
         sy       <= '0;
         sxx      <= '0;
         sxy      <= '0;
         p_nsxy   <= '0;
         p_sxsy   <= '0;
         p_nsxx   <= '0;
         p_sxsx   <= '0;
         m_prod   <= '0;
         num0_ph  <= 1'b0;
         div_rem  <= '0;
         div_q    <= '0;
         div_d    <= '0;
         div_neg  <= 1'b0;
         div_cnt  <= '0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         b0       <= '0;
         b1       <= '0;
         degen    <= 1'b0;
         sat      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sx       <= '0;
                  sy       <= '0;
                  sxx      <= '0;
                  sxy      <= '0;
                  b0       <= '0;
                  b1       <= '0;
                  degen    <= 1'b0;
                  sat      <= 1'b0;
                  n_reg    <= n_clamp;
                  smp_left <= n_clamp;
                  busy     <= 1'b1;
                  if (n_clamp == '0) begin
                     degen <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     in_ready <= 1'b1;
                     state    <= ACC;
                  end
               end
            end
            ACC: begin
               if (in_valid) begin
                  sx       <= sx + xe;
                  sy       <= sy + ye;
                  sxx      <= sxx + xe * xe;
                  sxy      <= sxy + xe * ye;
                  smp_left <= smp_left - LOGN'(1);
                  if (smp_left == LOGN'(1)) begin
                     in_ready <= 1'b0;
                     state    <= PROD;
                  end
               end
            end
            PROD: begin
               p_nsxy <= ne * sxy;
               p_sxsy <= sx * sy;
               p_nsxx <= ne * sxx;
               p_sxsx <= sx * sx;
               state  <= DIFF;
            end
            DIFF: begin
               if (den_c == '0) begin
                  b1      <= '0;
                  degen   <= 1'b1;
                  num0_ph <= 1'b0;
                  state   <= NUM0;
               end else begin
                  div_rem <= '0;
                  div_q   <= mag(num_c <<< FRAC);
                  div_d   <= mag(den_c);
                  div_neg <= num_c[IW-1] ^ den_c[IW-1];
                  div_cnt <= CW'(IW);
                  state   <= DIV1;
               end
            end
            DIV1: begin
               div_rem <= rem_nxt;
               div_q   <= q_nxt;
               div_cnt <= div_cnt - CW'(1);
               if (div_cnt == CW'(1)) begin
                  b1      <= q_sat;
                  sat     <= sat | q_clip;
                  num0_ph <= 1'b0;
                  state   <= NUM0;
               end
            end
            NUM0: begin
               if (!num0_ph) begin
                  m_prod  <= b1e * sx;
                  num0_ph <= 1'b1;
               end else begin
                  div_rem <= '0;
                  div_q   <= mag(m_c);
                  div_d   <= mag(ne);
                  div_neg <= m_c[IW-1];
                  div_cnt <= CW'(IW);
                  state   <= DIV0;
               end
            end
            DIV0: begin
               div_rem <= rem_nxt;
               div_q   <= q_nxt;
               div_cnt <= div_cnt - CW'(1);
               if (div_cnt == CW'(1)) begin
                  b0    <= q_sat;
                  sat   <= sat | q_clip;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_linreg_coeff_engine.sv
// Directed bench for linreg_coeff_engine at W=20, FRAC=10, NMAX=16.
module tb_linreg_coeff_engine;

   localparam int W         = 20;
   localparam int LOGN      = 5;
   localparam int LAT_NORM  = 184;
   localparam int LAT_DEGEN = 94;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [LOGN-1:0]      n_samples = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [W-1:0]  x = '0;
   logic signed [W-1:0]  y = '0;
   logic                 busy, done, degen, sat;
   logic signed [W-1:0]  b0, b1;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int t_acc  = 0;

   linreg_coeff_engine #(.W(20), .FRAC(10), .NMAX(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .n_samples (n_samples),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .busy      (busy),
      .done      (done),
      .b0        (b0),
      .b1        (b1),
      .degen     (degen),
      .sat       (sat)
   );

   always #5 clk = ~clk;

   // edge counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_start(input int n);
      @(negedge clk);
      start     = 1'b1;
      n_samples = LOGN'(n);
      @(negedge clk);
      start     = 1'b0;
   endtask

   // gap idle cycles with junk data, then one valid sample
   task automatic feed(input int xv, input int yv, input int gap);
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         x = W'($urandom);
         y = W'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      x = W'(xv);
      y = W'(yv);
      if (in_ready) t_acc = cyc + 1;
      @(negedge clk);
      in_valid = 1'b0;
      x = W'($urandom);
      y = W'($urandom);
   endtask

   task automatic feed_line(input int n);
      for (int k = 0; k < n; k++) feed(k * 1024, (2 * k + 1) * 1024, 0);
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i < 400; i++) begin
         if (done) begin
            lat = cyc - t_acc;
            break;
         end
         @(negedge clk);
      end
   endtask

   // waits for done, checks results, then checks a start in DONE is ignored
   task automatic check_result(input string tag, input int exp_lat, input int eb0,
                               input int eb1, input int edeg, input int esat);
      int lat;
      wait_done(lat);
      chk({tag, ".latency"}, lat, exp_lat);
      chk({tag, ".b0"}, b0, eb0);
      chk({tag, ".b1"}, b1, eb1);
      chk({tag, ".degen"}, degen, edeg);
      chk({tag, ".sat"}, sat, esat);
      chk({tag, ".busy_in_done"}, busy, 1);
      start     = 1'b1;
      n_samples = '0;
      @(negedge clk);
      start     = 1'b0;
      chk({tag, ".busy_after"}, busy, 0);
      chk({tag, ".done_after"}, done, 0);
      chk({tag, ".b1_held"}, b1, eb1);
   endtask

   initial begin
      int seen;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.busy", busy, 0);
      chk("rst.in_ready", in_ready, 0);
      chk("rst.done", done, 0);
      chk("rst.b0", b0, 0);
      chk("rst.b1", b1, 0);
      chk("rst.degen", degen, 0);
      chk("rst.sat", sat, 0);
      rst = 1'b1;
      @(negedge clk);

      // exact line, slope 2
      do_start(8);
      chk("s1.busy", busy, 1);
      chk("s1.in_ready", in_ready, 1);
      feed_line(8);
      chk("s1.in_ready_off", in_ready, 0);
      check_result("s1", LAT_NORM, 1024, 2048, 0, 0);

      // negative slope with backpressure gaps
      do_start(4);
      feed(0, 3072, 1);
      feed(1024, 2560, 2);
      feed(2048, 2048, 1);
      feed(3072, 1536, 3);
      check_result("s2", LAT_NORM, 3072, -512, 0, 0);

      // constant x
      do_start(4);
      feed(3072, 1024, 0);
      feed(3072, 2048, 0);
      feed(3072, 3072, 0);
      feed(3072, 4096, 0);
      check_result("s3", LAT_DEGEN, 2560, 0, 1, 0);

      // slope saturation
      do_start(2);
      feed(0, 0, 0);
      feed(1, 523264, 0);
      check_result("s4", LAT_NORM, 261376, 524287, 0, 1);

      // start pulsed during the slope divide
      do_start(8);
      feed_line(8);
      repeat (20) @(negedge clk);
      start     = 1'b1;
      n_samples = LOGN'(2);
      @(negedge clk);
      start     = 1'b0;
      chk("s5a.busy", busy, 1);
      check_result("s5a", LAT_NORM, 1024, 2048, 0, 0);

      // zero samples
      do_start(0);
      chk("s5b.done", done, 1);
      chk("s5b.busy", busy, 1);
      chk("s5b.b0", b0, 0);
      chk("s5b.b1", b1, 0);
      chk("s5b.degen", degen, 1);
      @(negedge clk);
      chk("s5b.done_off", done, 0);
      chk("s5b.busy_off", busy, 0);

      // count above NMAX clamps to 16
      do_start(31);
      feed_line(16);
      chk("s5c.in_ready_off", in_ready, 0);
      check_result("s5c", LAT_NORM, 1024, 2048, 0, 0);

      // single sample
      do_start(1);
      feed(5, 777, 0);
      check_result("s5d", LAT_DEGEN, 777, 0, 1, 0);

      // asynchronous reset during the intercept divide
      do_start(8);
      feed_line(8);
      repeat (150) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("s6.busy", busy, 0);
      chk("s6.outs", {in_ready, done, degen, sat, b0, b1}, 0);
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("s6.no_done", seen, 0);
      do_start(8);
      feed_line(8);
      check_result("s6r", LAT_NORM, 1024, 2048, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
